// File: rtl/rvh_l1d_pkg.sv
// Shared L1D snoop-path definitions: address/data widths, snoop type codes,
// responder beat layout and the snoop initiator state encoding.
package rvh_l1d_pkg;

  localparam int PADDR_W        = 20;
  localparam int LINE_OFFSET_W  = 6;
  localparam int LINE_ADDR_BITS = PADDR_W - LINE_OFFSET_W;
  localparam int MEM_DATA_W     = 64;
  localparam int LINE_W         = 512;

  localparam int SNP_TYPE_W = 4;
  localparam logic [SNP_TYPE_W-1:0] SNP_TYPE_SHARED   = 4'd8;
  localparam logic [SNP_TYPE_W-1:0] SNP_TYPE_UNIQUE   = 4'd9;
  localparam logic [SNP_TYPE_W-1:0] SNP_TYPE_MAKE_INV = 4'd11;

  // Responder beat: [65] data/flag, [64:1] data, [0] terminating ack
  localparam int RESP_W = 1 + MEM_DATA_W + 1;

  typedef struct packed {
    logic                  flag;
    logic [MEM_DATA_W-1:0] data;
    logic                  ack;
  } snp_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_BEAT,
    ST_CPL
  } snp_state_e;

endpackage

// File: rtl/snoop_beat_buf.sv
// Assembles a cache line from consecutive response beats; the first beat of
// a snoop always lands in slot 0 and the counter wraps after the last slot.
module snoop_beat_buf
  import rvh_l1d_pkg::*;
#(
  parameter int BEATS = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        beat_we,
  input  logic                        beat_first,
  input  logic [MEM_DATA_W-1:0]       beat_data,
  output logic                        beat_last,
  output logic [BEATS*MEM_DATA_W-1:0] line_data
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            idx;
  logic [BEATS*MEM_DATA_W-1:0] line_q;

  assign idx       = beat_first ? '0 : cnt_q;
  assign beat_last = beat_we && (idx == CNT_W'(BEATS - 1));
  assign line_data = line_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else if (beat_we) begin
      line_q[int'(idx)*MEM_DATA_W +: MEM_DATA_W] <= beat_data;
      cnt_q <= beat_last ? '0 : idx + CNT_W'(1);
    end
  end

endmodule

// File: rtl/snoop_initiator.sv
// Forwards one home-agent snoop at a time to the responder and returns a
// single completion: plain ack, assembled data line, or timeout.
//   state | meaning
//   IDLE  | accept a home request while the responder is empty
//   ISSUE | present sn_req until the responder takes it
//   WAIT  | await the first response beat, timeout running
//   BEAT  | collect the remaining data beats, timeout running
//   CPL   | hold the completion until home accepts it
module snoop_initiator
  import rvh_l1d_pkg::*;
#(
  parameter int LINE_ADDR_W = 14,
  parameter int BEATS       = 8,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              home_req_valid_i,
  output logic                              home_req_ready_o,
  input  logic [LINE_ADDR_W-1:0]            home_req_addr_i,
  input  logic [SNP_TYPE_W-1:0]             home_req_type_i,
  output logic [LINE_ADDR_W+SNP_TYPE_W-1:0] sn_req_o,
  output logic                              sn_req_valid_o,
  input  logic                              sn_req_ready_i,
  input  logic                              sn_empty_i,
  input  logic                              sn_resp_valid_i,
  input  logic [RESP_W-1:0]                 sn_resp_i,
  output logic                              home_cpl_valid_o,
  input  logic                              home_cpl_ready_i,
  output logic                              home_cpl_has_data_o,
  output logic                              home_cpl_flag_o,
  output logic [BEATS*MEM_DATA_W-1:0]       home_cpl_data_o,
  output logic                              home_cpl_timeout_o,
  output logic                              proto_err_o
);

  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  snp_state_e              state_q, state_d;
  snp_resp_t               resp;
  logic                    live_q;
  logic [LINE_ADDR_W-1:0]  addr_q;
  logic [SNP_TYPE_W-1:0]   type_q;
  logic [TMO_W-1:0]        tmo_q;
  logic                    cpl_has_data_q, cpl_flag_q, cpl_timeout_q, proto_err_q;
  logic                    in_rx, tmo_hit, rx_ack, rx_first, rx_beat;
  logic                    beat_we, beat_last, tmo_fire, done;
  logic                    stray, bad_wait, bad_beat;

  assign resp     = snp_resp_t'(sn_resp_i);
  assign in_rx    = (state_q == ST_WAIT) || (state_q == ST_BEAT);
  assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  assign rx_ack   = (state_q == ST_WAIT) && sn_resp_valid_i && resp.ack;
  assign rx_first = (state_q == ST_WAIT) && sn_resp_valid_i && resp.flag && !resp.ack;
  assign rx_beat  = (state_q == ST_BEAT) && sn_resp_valid_i;
  assign beat_we  = rx_first || rx_beat;
  // A beat that completes the snoop in the same cycle wins over the timeout
  assign tmo_fire = tmo_hit && (((state_q == ST_WAIT) && !rx_ack && !rx_first) ||
                                ((state_q == ST_BEAT) && !beat_last));
  assign done     = rx_ack || beat_last || tmo_fire;

  assign stray    = sn_resp_valid_i && !in_rx;
  assign bad_wait = (state_q == ST_WAIT) && sn_resp_valid_i && !resp.ack && !resp.flag;
  assign bad_beat = rx_beat && (!resp.flag || resp.ack);

  snoop_beat_buf #(.BEATS(BEATS)) u_beat_buf (
    .clk        (clk),
    .rstn       (rstn),
    .beat_we    (beat_we),
    .beat_first (state_q == ST_WAIT),
    .beat_data  (resp.data),
    .beat_last  (beat_last),
    .line_data  (home_cpl_data_o)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (home_req_valid_i && home_req_ready_o) state_d = ST_ISSUE;
      ST_ISSUE: if (sn_req_ready_i) state_d = ST_WAIT;
      ST_WAIT: begin
        if (done)          state_d = ST_CPL;
        else if (rx_first) state_d = ST_BEAT;
      end
      ST_BEAT:  if (done) state_d = ST_CPL;
      ST_CPL:   if (home_cpl_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // live_q keeps home_req_ready low while reset is held
  always_comb begin
    home_req_ready_o = 1'b0;
    sn_req_valid_o   = 1'b0;
    home_cpl_valid_o = 1'b0;
    unique case (state_q)
      ST_IDLE:  home_req_ready_o = live_q && sn_empty_i;
      ST_ISSUE: sn_req_valid_o   = 1'b1;
      ST_CPL:   home_cpl_valid_o = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      live_q         <= 1'b0;
      addr_q         <= '0;
      type_q         <= '0;
      tmo_q          <= '0;
      cpl_has_data_q <= 1'b0;
      cpl_flag_q     <= 1'b0;
      cpl_timeout_q  <= 1'b0;
      proto_err_q    <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if ((state_q == ST_IDLE) && home_req_valid_i && home_req_ready_o) begin
        addr_q <= home_req_addr_i;
        type_q <= home_req_type_i;
      end
      if ((state_q == ST_ISSUE) && sn_req_ready_i) tmo_q <= '0;
      else if (in_rx)                              tmo_q <= tmo_q + TMO_W'(1);
      if (done) begin
        cpl_has_data_q <= beat_last;
        cpl_flag_q     <= rx_ack && resp.flag;
        cpl_timeout_q  <= tmo_fire;
      end
      if (stray || bad_wait || bad_beat) proto_err_q <= 1'b1;
    end
  end

  assign sn_req_o            = {addr_q, type_q};
  assign home_cpl_has_data_o = cpl_has_data_q;
  assign home_cpl_flag_o     = cpl_flag_q;
  assign home_cpl_timeout_o  = cpl_timeout_q;
  assign proto_err_o         = proto_err_q;

endmodule

// File: tb/tb_snoop_initiator.sv
// Randomised bench for snoop_initiator: each snoop is described by its
// outcome kind, and the expected completion is derived from that kind.
module tb_snoop_initiator;

  localparam int LINE_ADDR_W = 14;
  localparam int BEATS       = 8;
  localparam int TIMEOUT_CYC = 256;
  localparam int LW          = BEATS * 64;
  localparam int K_ACK = 0, K_DATA = 1, K_TMO = 2, K_BAD = 3;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic                   home_req_valid_i = 1'b0;
  logic                   home_req_ready_o;
  logic [LINE_ADDR_W-1:0] home_req_addr_i = '0;
  logic [3:0]             home_req_type_i = '0;
  logic [17:0]            sn_req_o;
  logic                   sn_req_valid_o;
  logic                   sn_req_ready_i = 1'b0;
  logic                   sn_empty_i = 1'b1;
  logic                   sn_resp_valid_i = 1'b0;
  logic [65:0]            sn_resp_i = '0;
  logic                   home_cpl_valid_o;
  logic                   home_cpl_ready_i = 1'b0;
  logic                   home_cpl_has_data_o;
  logic                   home_cpl_flag_o;
  logic [LW-1:0]          home_cpl_data_o;
  logic                   home_cpl_timeout_o;
  logic                   proto_err_o;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic exp_perr = 1'b0;
  logic [3:0] types [3] = '{4'd8, 4'd9, 4'd11};

  snoop_initiator #(
    .LINE_ADDR_W (LINE_ADDR_W),
    .BEATS       (BEATS),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .home_req_valid_i    (home_req_valid_i),
    .home_req_ready_o    (home_req_ready_o),
    .home_req_addr_i     (home_req_addr_i),
    .home_req_type_i     (home_req_type_i),
    .sn_req_o            (sn_req_o),
    .sn_req_valid_o      (sn_req_valid_o),
    .sn_req_ready_i      (sn_req_ready_i),
    .sn_empty_i          (sn_empty_i),
    .sn_resp_valid_i     (sn_resp_valid_i),
    .sn_resp_i           (sn_resp_i),
    .home_cpl_valid_o    (home_cpl_valid_o),
    .home_cpl_ready_i    (home_cpl_ready_i),
    .home_cpl_has_data_o (home_cpl_has_data_o),
    .home_cpl_flag_o     (home_cpl_flag_o),
    .home_cpl_data_o     (home_cpl_data_o),
    .home_cpl_timeout_o  (home_cpl_timeout_o),
    .proto_err_o         (proto_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, home_req_ready_o, 1'b0);
    chk({tag, "_sn_valid"}, sn_req_valid_o, 1'b0);
    chk({tag, "_sn_req"}, sn_req_o, '0);
    chk({tag, "_cpl_valid"}, home_cpl_valid_o, 1'b0);
    chk({tag, "_cpl_fields"}, {home_cpl_has_data_o, home_cpl_flag_o, home_cpl_timeout_o}, '0);
    chk({tag, "_cpl_data"}, home_cpl_data_o, '0);
    chk({tag, "_perr"}, proto_err_o, 1'b0);
  endtask

  task automatic chk_cpl(input string tag, input int kind, input logic ack_flag,
                         input logic [LW-1:0] exp_line, input logic [LW-1:0] mask);
    chk({tag, "_valid"}, home_cpl_valid_o, 1'b1);
    chk({tag, "_has_data"}, home_cpl_has_data_o, (kind == K_DATA || kind == K_BAD));
    chk({tag, "_timeout"}, home_cpl_timeout_o, (kind == K_TMO));
    if (kind == K_ACK) chk({tag, "_flag"}, home_cpl_flag_o, ack_flag);
    if (kind == K_DATA || kind == K_BAD)
      chk({tag, "_data"}, home_cpl_data_o & mask, exp_line);
    chk({tag, "_perr"}, proto_err_o, exp_perr);
  endtask

  task automatic run_txn(input logic [13:0] addr, input logic [3:0] typ, input int kind,
                         input logic ack_flag, input int empty_lag, input int req_stall,
                         input int cpl_stall, input int max_gap, input logic seq_data);
    logic [17:0]   exp_req;
    logic [LW-1:0] exp_line, mask;
    logic [63:0]   d;
    int            hs_cyc, n, bad_k;
    exp_req  = {addr, typ};
    exp_line = '0;
    mask     = '0;
    home_req_addr_i  = addr;
    home_req_type_i  = typ;
    home_req_valid_i = 1'b1;
    sn_empty_i       = (empty_lag == 0);
    for (int i = 0; i < empty_lag; i++) begin
      #1 chk("req_ready_busy", home_req_ready_o, 1'b0);
      cyc1();
    end
    sn_empty_i = 1'b1;
    #1 chk("req_ready_idle", home_req_ready_o, 1'b1);
    cyc1();
    chk("sn_req_valid", sn_req_valid_o, 1'b1);
    chk("sn_req", sn_req_o, exp_req);
    // A competing request stays asserted; it must never be taken mid-snoop
    home_req_addr_i = ~addr;
    for (int i = 0; i < req_stall; i++) begin
      cyc1();
      chk("sn_req_hold_valid", sn_req_valid_o, 1'b1);
      chk("sn_req_hold", sn_req_o, exp_req);
      chk("req_ready_busy2", home_req_ready_o, 1'b0);
    end
    sn_req_ready_i = 1'b1;
    cyc1();
    sn_req_ready_i = 1'b0;
    hs_cyc = cyc;
    chk("sn_req_dropped", sn_req_valid_o, 1'b0);

    if (kind == K_ACK) begin
      repeat ($urandom_range(0, max_gap)) begin
        chk("cpl_early", home_cpl_valid_o, 1'b0);
        cyc1();
      end
      sn_resp_valid_i = 1'b1;
      sn_resp_i = {ack_flag, $urandom(), $urandom(), 1'b1};
      cyc1();
      sn_resp_valid_i = 1'b0;
    end else if (kind == K_TMO) begin
      n = 0;
      while (!home_cpl_valid_o && n < 2 * TIMEOUT_CYC) begin
        cyc1();
        n++;
      end
      chk("tmo_latency", cyc - hs_cyc, TIMEOUT_CYC);
    end else begin
      bad_k = (kind == K_BAD) ? int'($urandom_range(1, BEATS - 1)) : -1;
      for (int k = 0; k < BEATS; k++) begin
        repeat ($urandom_range(0, max_gap)) begin
          chk("cpl_early", home_cpl_valid_o, 1'b0);
          cyc1();
        end
        if (k > 0) chk("cpl_early_beat", home_cpl_valid_o, 1'b0);
        d = seq_data ? 64'(k) : {$urandom(), $urandom()};
        if (k == bad_k) begin
          sn_resp_i = ($urandom_range(0, 1) == 0) ? {1'b0, d, 1'b0} : {1'b1, d, 1'b1};
          exp_perr  = 1'b1;
        end else begin
          sn_resp_i = {1'b1, d, 1'b0};
          exp_line[k*64 +: 64] = d;
          mask[k*64 +: 64]     = '1;
        end
        sn_resp_valid_i = 1'b1;
        cyc1();
        sn_resp_valid_i = 1'b0;
      end
    end

    chk_cpl("cpl", kind, ack_flag, exp_line, mask);
    for (int i = 0; i < cpl_stall; i++) begin
      cyc1();
      chk_cpl("cpl_hold", kind, ack_flag, exp_line, mask);
      chk("req_ready_in_cpl_wait", home_req_ready_o, 1'b0);
    end
    home_cpl_ready_i = 1'b1;
    #1 chk("req_ready_cpl_hs", home_req_ready_o, 1'b0);
    cyc1();
    home_cpl_ready_i = 1'b0;
    home_req_valid_i = 1'b0;
    chk("cpl_dropped", home_cpl_valid_o, 1'b0);
    chk("no_bypass_issue", sn_req_valid_o, 1'b0);
  endtask

  initial begin
    int r, kind;
    int stuck;
    #2;
    chk_reset_outputs("por");
    cyc1();
    rstn = 1'b1;
    cyc1();
    cyc1();

    run_txn(14'h1A2B, 4'd11, K_ACK, 1'b0, 0, 0, 0, 0, 1'b0);
    run_txn(14'h0123, 4'd8, K_DATA, 1'b0, 0, 0, 0, 0, 1'b1);
    run_txn(14'h3FFF, 4'd9, K_ACK, 1'b1, 0, 5, 3, 2, 1'b0);
    run_txn(14'h0000, 4'd8, K_TMO, 1'b0, 0, 0, 1, 0, 1'b0);
    run_txn(14'h2222, 4'd11, K_DATA, 1'b0, 4, 2, 2, 2, 1'b0);

    for (int t = 0; t < 24; t++) begin
      r = int'($urandom_range(0, 9));
      kind = (r < 4) ? K_ACK : (r < 8) ? K_DATA : (r == 8) ? K_TMO : K_BAD;
      run_txn(14'($urandom()), types[$urandom_range(0, 2)], kind, 1'($urandom()),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 2, 1'b0);
    end

    // Stray beat while idle, then reset in the middle of a data snoop
    sn_resp_valid_i = 1'b1;
    sn_resp_i = {2'b11, $urandom(), $urandom()};
    cyc1();
    sn_resp_valid_i = 1'b0;
    exp_perr = 1'b1;
    chk("perr_stray", proto_err_o, exp_perr);
    home_req_addr_i  = 14'h0ABC;
    home_req_type_i  = 4'd8;
    home_req_valid_i = 1'b1;
    cyc1();
    home_req_valid_i = 1'b0;
    sn_req_ready_i   = 1'b1;
    cyc1();
    sn_req_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sn_resp_i = {1'b1, 64'hA5A5_0000_0000_0000 | 64'(k), 1'b0};
      sn_resp_valid_i = 1'b1;
      cyc1();
    end
    sn_resp_i = {1'b1, 64'hDEAD_BEEF, 1'b0};
    chk("perr_before_rst", proto_err_o, 1'b1);
    #2 rstn = 1'b0;
    #1 sn_resp_valid_i = 1'b0;
    exp_perr = 1'b0;
    chk_reset_outputs("midrst");
    cyc1();
    cyc1();
    rstn = 1'b1;
    stuck = 0;
    for (int i = 0; i < 12; i++) begin
      cyc1();
      if (home_cpl_valid_o) stuck++;
    end
    chk("no_cpl_after_rst", stuck, 0);
    chk("perr_after_rst", proto_err_o, 1'b0);
    run_txn(14'h1357, 4'd9, K_DATA, 1'b0, 0, 1, 1, 1, 1'b0);
    run_txn(14'h2468, 4'd8, K_BAD, 1'b0, 0, 0, 0, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
